// File: rtl/pc_redirect_unit.sv
// Fetch-side PC sequencer: owns the fetch PC, steps it on instruction-memory
// completion, redirects on branch/jump with a flush window, and parks on HALT.
module pc_redirect_unit #(
    parameter int                     PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
    parameter int                     FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branchEN,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                stall_in,
    input  logic                halt_in,
    input  logic                imem_done,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus2,
    output logic                fetch_req,
    output logic                fetch_valid,
    output logic                flush,
    output logic                halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t              state, state_next;
    logic [2:0]          flush_cnt, flush_cnt_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] target_raw;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                redirect;

    // Jump wins over branch; targets are halfword aligned.
    assign redirect        = jump_en | branchEN;
    assign target_raw      = jump_en ? jump_target : branch_target;
    assign redirect_target = {target_raw[PC_WIDTH-1:1], 1'b0};
    assign pc_plus2        = pc + PC_WIDTH'(2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            flush_cnt <= 3'd0;
            pc        <= RESET_PC;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            pc        <= pc_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        pc_next        = pc;
        fetch_req      = 1'b0;
        fetch_valid    = 1'b0;
        flush          = 1'b0;
        halted         = 1'b0;

        case (state)
            FETCH: begin
                fetch_req = 1'b1;
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_target;
                    if (FLUSH_CYCLES > 0) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_LOAD;
                    end
                end else if (stall_in) begin
                    pc_next = pc;
                end else if (imem_done) begin
                    fetch_valid = 1'b1;
                    if (halt_in) state_next = HALT;
                    else         pc_next    = pc_plus2;
                end
            end
            // Inputs here come from squashed instructions and are ignored.
            FLUSH: begin
                flush          = 1'b1;
                flush_cnt_next = flush_cnt - 3'd1;
                if (flush_cnt == 3'd1) state_next = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Combinational outputs must read quiet while reset is held.
        if (rst) begin
            fetch_req   = 1'b0;
            fetch_valid = 1'b0;
            flush       = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: reset, sequential fetch, redirects with
// flush window, memory wait/stall, HALT parking and PC wraparound.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchEN;
    logic [15:0] branch_target;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        stall_in;
    logic        halt_in;
    logic        imem_done;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_req;
    logic        fetch_valid;
    logic        flush;
    logic        halted;

    int n_compared   = 0;
    int n_mismatched = 0;

    pc_redirect_unit #(
        .PC_WIDTH    (16),
        .RESET_PC    (16'h0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branchEN     (branchEN),
        .branch_target(branch_target),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .stall_in     (stall_in),
        .halt_in      (halt_in),
        .imem_done    (imem_done),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .fetch_req    (fetch_req),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all status outputs for the cycle currently presented.
    task automatic check_cycle(input string tag, input logic [15:0] exp_pc,
                               input logic exp_req, input logic exp_valid,
                               input logic exp_flush, input logic exp_halted);
        check({tag, ".pc"},          pc,                  exp_pc);
        check({tag, ".pc_plus2"},    pc_plus2,            exp_pc + 16'd2);
        check({tag, ".fetch_req"},   16'(fetch_req),      16'(exp_req));
        check({tag, ".fetch_valid"}, 16'(fetch_valid),    16'(exp_valid));
        check({tag, ".flush"},       16'(flush),          16'(exp_flush));
        check({tag, ".halted"},      16'(halted),         16'(exp_halted));
    endtask

    // Inputs are applied just after the falling edge; outputs settle by #1.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Redirect from FETCH at cur_pc to new_pc: three flush cycles, then fetch.
    // branchEN is pulsed during the flush window to prove it is ignored.
    task automatic redirect_seq(input string tag, input logic [15:0] cur_pc,
                                input logic j, input logic [15:0] jt,
                                input logic b, input logic [15:0] bt,
                                input logic [15:0] new_pc);
        jump_en = j; jump_target = jt; branchEN = b; branch_target = bt;
        #1;
        check_cycle({tag, ".redir"}, cur_pc, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        jump_en = 1'b0; branchEN = 1'b1; branch_target = 16'h0200;
        #1;
        check_cycle({tag, ".fl1"}, new_pc, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        branchEN = 1'b1; branch_target = 16'h0300;
        #1;
        check_cycle({tag, ".fl2"}, new_pc, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        branchEN = 1'b0;
        #1;
        check_cycle({tag, ".resume"}, new_pc, 1'b1, imem_done, 1'b0, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; branchEN = 1'b0; branch_target = '0; jump_en = 1'b0;
        jump_target = '0; stall_in = 1'b0; halt_in = 1'b0; imem_done = 1'b1;

        // Reset: outputs quiet even with imem_done high.
        repeat (2) @(negedge clk);
        #1;
        check_cycle("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;

        // Sequential fetch 0000, 0002, 0004, 0006.
        check_cycle("seq0", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); check_cycle("seq1", 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); check_cycle("seq2", 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); check_cycle("seq3", 16'h0006, 1'b1, 1'b1, 1'b0, 1'b0);

        // Branch at 0006 to 0040, then sequential step to 0042.
        redirect_seq("br", 16'h0006, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0040);
        next_cycle(); check_cycle("br.step", 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);

        // Jump and branch together: jump wins.
        redirect_seq("jb", 16'h0042, 1'b1, 16'h0100, 1'b1, 16'h0080, 16'h0100);

        // Jump to 0010 with memory busy on arrival.
        imem_done = 1'b0;
        redirect_seq("j10", 16'h0100, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0010);
        next_cycle(); check_cycle("wait1", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        stall_in = 1'b1;
        next_cycle(); check_cycle("wait2", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        imem_done = 1'b1; #1;
        check_cycle("stall_done", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        stall_in = 1'b0; #1;
        check_cycle("done", 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); check_cycle("adv", 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0);

        // HALT at 0020; redirects ignored while parked; reset exits.
        redirect_seq("j20", 16'h0012, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0020);
        halt_in = 1'b1; #1;
        check_cycle("halt_fetch", 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        halt_in = 1'b0; jump_en = 1'b1; jump_target = 16'h0500; #1;
        check_cycle("halted1", 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle(); check_cycle("halted2", 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1);
        jump_en = 1'b0;
        next_cycle(); check_cycle("halted3", 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; #1;
        check_cycle("halt_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0; #1;
        check_cycle("post_rst", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); check_cycle("post_rst1", 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);

        // Wrap FFFE -> 0000, then odd branch target aligned down.
        redirect_seq("jwrap", 16'h0002, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE);
        check("wrap.p2", pc_plus2, 16'h0000);
        next_cycle(); check_cycle("wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        redirect_seq("odd", 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0043, 16'h0042);

        // Redirect to the current pc still flushes.
        redirect_seq("self", 16'h0042, 1'b1, 16'h0042, 1'b0, 16'h0000, 16'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
